eliminate_ctrl: RTL and testbench

Sequential controller that performs one elimination move on the 8x8 game board. On a confirmed selection at cursor (x, y) it flood-fills the same-colour connected group, clears it if it has at least 2 cells, and applies gravity column by column. It reports the number of removed cells and presents the settled board. It sits between the cursor/confirm input logic and the board register owned by the top-level game FSM, which writes `board_o` back when `done` pulses.

---
 rtl/game_pkg.sv | 23 ++
 rtl/board_gravity_step.sv | 49 ++++
 rtl/eliminate_ctrl.sv | 137 +++++++++++++
 tb/tb_eliminate_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared board geometry, colour encoding and controller state type for the
// elimination game datapath.
package game_pkg;
   localparam int BOARD_N = 8;
   localparam int COLOR_W = 3;
   localparam int CELLS   = BOARD_N * BOARD_N;
   localparam int COL_W   = BOARD_N * COLOR_W;
   localparam logic [COLOR_W-1:0] EMPTY = 3'd0;

   typedef logic [CELLS*COLOR_W-1:0] board_t;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GROW  = 3'd1,
      S_CLEAR = 3'd2,
      S_FALL  = 3'd3,
      S_DONE  = 3'd4
   } elim_state_t;

   function automatic int idx(input int r, input int c);
      return r * BOARD_N + c;
   endfunction
endpackage

// File: rtl/board_gravity_step.sv
// One combinational gravity step: every column independently drops the cells
// above its lowest hole by one row.
module board_gravity_step
   import game_pkg::*;
(
   input  board_t i_board,
   output board_t o_board,
   output logic   o_moved
);

   // Column vector holds row r at bits [r*COLOR_W +: COLOR_W]; MSB of result is the shift flag.
   function automatic logic [COL_W:0] drop_col(input logic [COL_W-1:0] col);
      int                 low;
      logic               hit;
      logic [COL_W-1:0]   res;
      low = -1;
      for (int r = 0; r < BOARD_N; r++)
         if (col[r*COLOR_W +: COLOR_W] == EMPTY) low = r;
      hit = 1'b0;
      for (int r = 0; r < BOARD_N; r++)
         if (r < low && col[r*COLOR_W +: COLOR_W] != EMPTY) hit = 1'b1;
      res = col;
      if (hit) begin
         for (int r = 0; r < BOARD_N; r++) begin
            if (r == 0) res[0 +: COLOR_W] = EMPTY;
            else if (r <= low) res[r*COLOR_W +: COLOR_W] = col[(r-1)*COLOR_W +: COLOR_W];
         end
      end
      return {hit, res};
   endfunction

   always_comb begin
      logic [COL_W-1:0] w_col;
      logic [COL_W:0]   w_res;
      o_board = i_board;
      o_moved = 1'b0;
      w_col   = '0;
      w_res   = '0;
      for (int c = 0; c < BOARD_N; c++) begin
         for (int r = 0; r < BOARD_N; r++)
            w_col[r*COLOR_W +: COLOR_W] = i_board[idx(r, c)*COLOR_W +: COLOR_W];
         w_res   = drop_col(w_col);
         o_moved = o_moved | w_res[COL_W];
         for (int r = 0; r < BOARD_N; r++)
            o_board[idx(r, c)*COLOR_W +: COLOR_W] = w_res[r*COLOR_W +: COLOR_W];
      end
   end

endmodule

// File: rtl/eliminate_ctrl.sv
// Elimination move controller: flood-fills the selected colour group, clears it
// when it has two or more cells, then settles the board under gravity.
module eliminate_ctrl
   import game_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [3:0]   x,
   input  logic [3:0]   y,
   input  board_t       board_i,
   output logic         busy,
   output logic         done,
   output logic [6:0]   removed,
   output logic         bad_sel,
   output board_t       board_o
);

   localparam logic [CELLS-1:0] COL0_MASK = 64'h0101_0101_0101_0101;
   localparam logic [CELLS-1:0] COL7_MASK = 64'h8080_8080_8080_8080;

   elim_state_t          r_state;
   board_t               r_work;
   board_t               r_board_o;
   logic [CELLS-1:0]     r_mask;
   logic [COLOR_W-1:0]   r_color;
   logic [6:0]           r_removed;
   logic                 r_bad;
   logic                 r_done;

   logic [5:0]           w_sel_idx;
   logic [COLOR_W-1:0]   w_sel_color;
   logic                 w_sel_ok;
   logic [CELLS-1:0]     w_same;
   logic [CELLS-1:0]     w_nbr;
   logic [CELLS-1:0]     w_grow;
   logic [6:0]           w_cnt;
   board_t               w_cleared;
   board_t               w_fallen;
   logic                 w_moved;

   assign w_sel_idx   = {x[2:0], y[2:0]};
   assign w_sel_color = board_i[w_sel_idx*COLOR_W +: COLOR_W];
   assign w_sel_ok    = !x[3] && !y[3] && (w_sel_color != EMPTY);

   always_comb begin
      w_same    = '0;
      w_cleared = r_work;
      w_cnt     = '0;
      for (int i = 0; i < CELLS; i++) begin
         w_same[i] = (r_work[i*COLOR_W +: COLOR_W] == r_color);
         if (r_mask[i]) w_cleared[i*COLOR_W +: COLOR_W] = EMPTY;
         w_cnt = w_cnt + {6'd0, r_mask[i]};
      end
   end

   // Shifted copies of the mask; edge columns are cut so rows never wrap.
   assign w_nbr  = (r_mask << BOARD_N) | (r_mask >> BOARD_N)
                 | ((r_mask << 1) & ~COL0_MASK) | ((r_mask >> 1) & ~COL7_MASK);
   assign w_grow = r_mask | (w_nbr & w_same);

   board_gravity_step u_gravity (
      .i_board (r_work),
      .o_board (w_fallen),
      .o_moved (w_moved)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_work    <= '0;
         r_board_o <= '0;
         r_mask    <= '0;
         r_color   <= EMPTY;
         r_removed <= '0;
         r_bad     <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_removed <= '0;
                  r_bad     <= 1'b0;
                  if (w_sel_ok) begin
                     r_work  <= board_i;
                     r_color <= w_sel_color;
                     r_mask  <= 64'd1 << w_sel_idx;
                     r_state <= S_GROW;
                  end else begin
                     r_bad     <= 1'b1;
                     r_board_o <= board_i;
                     r_done    <= 1'b1;
                     r_state   <= S_DONE;
                  end
               end
            end
            S_GROW: begin
               if (w_grow == r_mask) begin
                  if (w_cnt < 7'd2) begin
                     r_board_o <= r_work;
                     r_done    <= 1'b1;
                     r_state   <= S_DONE;
                  end else begin
                     r_removed <= w_cnt;
                     r_state   <= S_CLEAR;
                  end
               end else begin
                  r_mask <= w_grow;
               end
            end
            S_CLEAR: begin
               r_work  <= w_cleared;
               r_state <= S_FALL;
            end
            S_FALL: begin
               if (w_moved) begin
                  r_work <= w_fallen;
               end else begin
                  r_board_o <= r_work;
                  r_done    <= 1'b1;
                  r_state   <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy    = (r_state != S_IDLE);
   assign done    = r_done;
   assign removed = r_removed;
   assign bad_sel = r_bad;
   assign board_o = r_board_o;

endmodule

// File: tb/tb_eliminate_ctrl.sv
// Scoreboard bench for eliminate_ctrl: directed moves push expected results,
// a monitor compares them whenever done pulses.
module tb_eliminate_ctrl;
   import game_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [3:0] x = '0;
   logic [3:0] y = '0;
   board_t     board_i = '0;
   logic       busy, done, bad_sel;
   logic [6:0] removed;
   board_t     board_o;

   eliminate_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .board_i(board_i),
      .busy(busy), .done(done), .removed(removed), .bad_sel(bad_sel), .board_o(board_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string      name;
      logic [6:0] rem;
      logic       bad;
      board_t     brd;
      int         dcyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic void chk(string name, logic [191:0] act, logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic board_t fill(logic [2:0] v);
      board_t b;
      for (int i = 0; i < CELLS; i++) b[i*COLOR_W +: COLOR_W] = v;
      return b;
   endfunction

   function automatic board_t put(board_t b, int r, int c, logic [2:0] v);
      b[idx(r, c)*COLOR_W +: COLOR_W] = v;
      return b;
   endfunction

   // Monitor: every done pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst && done) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending move");
         end else begin
            e = q.pop_front();
            chk({e.name, "_removed"}, 192'(removed), 192'(e.rem));
            chk({e.name, "_bad_sel"}, 192'(bad_sel), 192'(e.bad));
            chk({e.name, "_board"},   board_o,       e.brd);
            chk({e.name, "_latency"}, 192'(cyc),     192'(e.dcyc));
            chk({e.name, "_busy"},    192'(busy),    192'(1));
         end
      end
   end

   // Drive a start pulse; expected done cycle is the current count plus latency-1.
   task automatic issue(input string name, input board_t b, input int xi, input int yi,
                        input int rem, input bit bad, input board_t eb, input int lat,
                        input bit push);
      exp_t e;
      @(negedge clk);
      start   = 1'b1;
      x       = 4'(xi);
      y       = 4'(yi);
      board_i = b;
      if (push) begin
         e.name = name; e.rem = 7'(rem); e.bad = bad; e.brd = eb; e.dcyc = cyc + lat - 1;
         q.push_back(e);
      end
      @(negedge clk);
      start   = 1'b0;
      board_i = fill(3'd7);
      chk({name, "_busy_after_start"}, 192'(busy), 192'(1));
   endtask

   task automatic wait_done(input string name);
      int t = 0;
      while (!done && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no done expected done within 200 cycles", name);
      end
      @(negedge clk);
   endtask

   initial begin
      board_t b, e;
      int     ecnt[BOARD_N];

      repeat (3) @(negedge clk);
      chk("reset_busy",    192'(busy),    192'(0));
      chk("reset_done",    192'(done),    192'(0));
      chk("reset_removed", 192'(removed), 192'(0));
      chk("reset_bad_sel", 192'(bad_sel), 192'(0));
      chk("reset_board_o", board_o,       192'(0));
      rst = 1'b1;

      b = put(fill(3'd5), 3, 3, 3'd2);
      issue("single", b, 3, 3, 0, 1'b0, b, 3, 1'b1);
      wait_done("single");

      b = fill(3'd4);
      e = fill(3'd4);
      for (int c = 0; c < BOARD_N; c++) begin
         b = put(b, 7, c, 3'd1);
         e = put(e, 0, c, 3'd0);
      end
      issue("row7", b, 7, 0, 8, 1'b0, e, 13, 1'b1);
      wait_done("row7");

      b = fill(3'd5);
      for (int c = 0; c < BOARD_N; c++) begin
         b = put(b, 0, c, 3'd3);
         b = put(b, 2, c, 3'd3);
      end
      b = put(b, 1, 7, 3'd3);
      b = put(b, 3, 0, 3'd3);
      b = put(b, 4, 0, 3'd3);
      b = put(b, 4, 1, 3'd3);
      ecnt = '{4, 3, 2, 2, 2, 2, 2, 3};
      e = fill(3'd5);
      for (int c = 0; c < BOARD_N; c++)
         for (int r = 0; r < BOARD_N; r++)
            if (r < ecnt[c]) e = put(e, r, c, 3'd0);
      issue("snake", b, 4, 1, 20, 1'b0, e, 27, 1'b1);
      wait_done("snake");

      b = put(put(fill(3'd1), 0, 7, 3'd6), 1, 0, 3'd6);
      issue("nowrap", b, 0, 7, 0, 1'b0, b, 3, 1'b1);
      wait_done("nowrap");

      b = fill(3'd2);
      issue("bad_x", b, 9, 0, 0, 1'b1, b, 2, 1'b1);
      wait_done("bad_x");
      issue("bad_y", b, 0, 8, 0, 1'b1, b, 2, 1'b1);
      wait_done("bad_y");
      b = put(b, 2, 5, 3'd0);
      issue("bad_empty", b, 2, 5, 0, 1'b1, b, 2, 1'b1);
      wait_done("bad_empty");

      b = fill(3'd4);
      e = fill(3'd4);
      for (int c = 0; c < BOARD_N; c++) begin
         b = put(b, 7, c, 3'd1);
         e = put(e, 0, c, 3'd0);
      end
      issue("abort", b, 7, 0, 8, 1'b0, e, 13, 1'b0);
      repeat (9) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_busy",    192'(busy),    192'(0));
      chk("abort_done",    192'(done),    192'(0));
      chk("abort_removed", 192'(removed), 192'(0));
      chk("abort_bad_sel", 192'(bad_sel), 192'(0));
      chk("abort_board_o", board_o,       192'(0));
      @(negedge clk);
      rst = 1'b1;

      issue("rerun", b, 7, 0, 8, 1'b0, e, 13, 1'b1);
      repeat (3) @(negedge clk);
      start   = 1'b1;
      x       = 4'd0;
      y       = 4'd0;
      board_i = fill(3'd4);
      @(negedge clk);
      start = 1'b0;
      wait_done("rerun");
      repeat (20) @(negedge clk);
      chk("queue_empty", 192'(q.size()), 192'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
